// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller: registered lookup,
// single-line miss refill, flush, and saturating hit/miss statistics.
module dm_cache_ctrl #(
  parameter int ADDR_W         = 15,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 10,
  parameter int CNT_W          = 16,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [WORD_W-1:0]                resp_data,
  output logic                             resp_hit,
  input  logic                             flush,
  output logic                             mem_req_valid,
  output logic [ADDR_W-OFF_W-1:0]          mem_req_addr,
  input  logic                             mem_req_ready,
  input  logic                             mem_resp_valid,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_resp_data,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int LINES  = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESPOND
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-1:0]   off;
  logic [LINE_W-1:0]  line;
  logic [WORD_W-1:0]  word;
  logic               hit;
  logic               fill;

  assign {tag, idx, off} = addr_q;
  assign line = data_mem[idx];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign fill = (state_q == REFILL) && mem_resp_valid;

  // word 0 sits in the MSBs of the line
  always_comb begin
    word = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (OFF_W'(i) == off) begin
        word = line[(WORDS_PER_LINE-1-i)*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_resp_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    valid_d       = valid_q;
    rdata_d       = rdata_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n && !flush;
        if (flush) begin
          valid_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (mem_resp_valid) begin
          valid_d[idx] = 1'b1;
          state_d      = RESPOND;
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (resp_valid) begin
      rdata_d = word;
      if (resp_hit) begin
        if (hit_q != '1) hit_d = hit_q + 1'b1;
      end else begin
        if (miss_q != '1) miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign resp_data    = rdata_d;
  assign mem_req_addr = addr_q[ADDR_W-1:OFF_W];
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios plus random accesses
// checked against a tag/valid table and a fixed main-memory image.
module tb_dm_cache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic [14:0]  req_addr;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_hit;
  logic         flush;
  logic         mem_req_valid;
  logic [12:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int tests = 0;
  int fails = 0;

  bit         mv [1024];
  logic [2:0] mt [1024];
  int         exp_hits = 0;
  int         exp_miss = 0;

  dm_cache_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_hit       (resp_hit),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mem_line(input logic [12:0] la);
    logic [31:0] l;
    l = 32'(la);
    if (la == 13'd1) return {32'hA, 32'hB, 32'hC, 32'hD};
    return {32'hC0DE_0000 | l, 32'h1111_0000 | l,
            32'h2222_0000 | l, l * 32'h9E37_79B1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
  endtask

  task automatic access(input logic [14:0] a, input int st,
                        input int rw, input bit rflush);
    logic [2:0]   t;
    logic [9:0]   ix;
    int           off;
    bit           eh;
    int           n;
    int           st0;
    int           rw0;
    bit           got;
    bit           granted;
    bit           sent;
    bit           sawmem;
    logic [127:0] ln;
    logic [31:0]  ew;
    t   = a[14:12];
    ix  = a[11:2];
    off = int'(a[1:0]);
    eh  = mv[ix] && (mt[ix] == t);
    ln  = mem_line(a[14:2]);
    ew  = ln[(3-off)*32 +: 32];
    st0 = st;
    rw0 = rw;
    @(negedge clk);
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    #1;
    chk("req_ready", req_ready, 1);
    chk("idle_resp_valid", resp_valid, 0);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
    n = 0; got = 0; granted = 0; sent = 0; sawmem = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      req_addr = 15'($urandom);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      flush = rflush && ($urandom_range(0, 1) == 1);
      #1;
      if (mem_req_valid) begin
        sawmem = 1;
        chk("mem_req_addr", mem_req_addr, a[14:2]);
        if (st == 0) begin
          mem_req_ready = 1'b1;
          granted = 1;
        end else begin
          st--;
        end
      end else if (granted && !sent) begin
        if (rw == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = ln;
          sent = 1;
        end else begin
          rw--;
        end
      end else begin
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data = {4{$urandom}};
      end
      if (resp_valid) begin
        got = 1;
        chk("resp_hit", resp_hit, eh);
        chk("resp_data", resp_data, ew);
        chk("latency", n, eh ? 1 : 4 + st0 + rw0);
        chk("mem_fetch", sawmem, !eh);
      end
    end
    chk("resp_seen", got, 1);
    flush = 1'b0;
    if (eh) begin
      if (exp_hits < 65535) exp_hits++;
    end else begin
      mv[ix] = 1'b1;
      mt[ix] = t;
      if (exp_miss < 65535) exp_miss++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_hit"}, resp_hit, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_miss_count"}, miss_count, 0);
  endtask

  initial begin
    logic [9:0] ixs [4];
    logic [14:0] ra;
    ixs = '{10'd1, 10'd2, 10'd3, 10'd7};
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    access(15'h0005, 0, 0, 0);
    access(15'h0005, 0, 0, 0);
    access(15'h1005, 0, 0, 0);
    access(15'h0005, 0, 0, 0);
    access(15'h0005, 5, 0, 0);
    access(15'h0006, 2, 3, 1);

    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 15'h0005;
    #1;
    chk("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_no_resp", resp_valid, 0);
    chk("flush_no_mem", mem_req_valid, 0);
    model_clear();
    access(15'h0005, 0, 0, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 15'h0009;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_test_mem_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midmiss");
    mem_resp_valid = 1'b1;
    mem_resp_data = mem_line(13'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_mem_req", mem_req_valid, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("post_rst_resp_valid2", resp_valid, 0);
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
    access(15'h0009, 0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'($urandom_range(0, 1));
        #1;
        chk("rand_flush_ready", req_ready, 0);
        model_clear();
      end
      ra = {3'($urandom_range(0, 3)), ixs[$urandom_range(0, 3)],
            2'($urandom_range(0, 3))};
      access(ra, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    chk("final_hit_count", hit_count, exp_hits);
    chk("final_miss_count", miss_count, exp_miss);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
